// File: rtl/multi_race_arbiter.sv
// Parallel RO-PUF race arbiter: judges NUM_PAIRS oscillator races per start pulse,
// latching first-finisher, ties and a bounded-race timeout into one result word.

module mrace_judge #(
  parameter bit TIE_WINNER = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  input  logic f1,
  input  logic f2,
  output logic winner,
  output logic valid,
  output logic tie,
  output logic valid_nxt
);
  logic hit;

  // Only the first cycle either flag is seen counts; the pair is frozen afterwards.
  assign hit       = en & ~valid & (f1 | f2);
  assign valid_nxt = valid | hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      winner <= 1'b0;
      valid  <= 1'b0;
      tie    <= 1'b0;
    end else if (clear) begin
      winner <= 1'b0;
      valid  <= 1'b0;
      tie    <= 1'b0;
    end else if (hit) begin
      valid  <= 1'b1;
      tie    <= f1 & f2;
      winner <= (f1 & f2) ? TIE_WINNER : f1;
    end
  end
endmodule

module multi_race_arbiter #(
  parameter int NUM_PAIRS      = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter bit TIE_WINNER     = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NUM_PAIRS-1:0] finished1,
  input  logic [NUM_PAIRS-1:0] finished2,
  output logic [NUM_PAIRS-1:0] winner,
  output logic [NUM_PAIRS-1:0] valid,
  output logic [NUM_PAIRS-1:0] tie,
  output logic                 busy,
  output logic                 done,
  output logic                 timed_out
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, RACE, DONE} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt;
  logic                 enter, racing, tmo, all_valid;
  logic [NUM_PAIRS-1:0] valid_nxt;

  assign racing    = (state == RACE);
  assign tmo       = racing && (cnt == CNT_LAST);
  assign all_valid = &valid;

  mrace_judge #(.TIE_WINNER(TIE_WINNER)) u_judge [NUM_PAIRS-1:0] (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (enter),
    .en        (racing),
    .f1        (finished1),
    .f2        (finished2),
    .winner    (winner),
    .valid     (valid),
    .tie       (tie),
    .valid_nxt (valid_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    enter     = 1'b0;
    case (state)
      IDLE, DONE: if (start) begin
        state_nxt = RACE;
        enter     = 1'b1;
      end
      RACE: if (all_valid || tmo) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Saturating race-cycle counter; RACE never outlives TIMEOUT_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (!rst_n)                      cnt <= '0;
    else if (enter)                  cnt <= '0;
    else if (racing && cnt != CNT_MAX) cnt <= cnt + CW'(1);
  end

  // A pair resolving in the timeout cycle still counts, so look at next-cycle valid.
  always_ff @(posedge clk) begin
    if (!rst_n)                    timed_out <= 1'b0;
    else if (enter)                timed_out <= 1'b0;
    else if (tmo && !all_valid)    timed_out <= ~&valid_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt == RACE);
      done <= (state_nxt == DONE);
    end
  end
endmodule

// File: tb/tb_multi_race_arbiter.sv
// Directed bench: two arbiters (TIE_WINNER 0/1) share stimulus; a schedule-driven model
// pushes expected results that are popped when done rises.

module tb_multi_race_arbiter;
  localparam int NP = 4;
  localparam int TO = 16;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [NP-1:0] f1 = '0, f2 = '0;
  logic [NP-1:0] w0, v0, t0, w1, v1, t1;
  logic          b0, d0, to0, b1, d1, to1;

  multi_race_arbiter #(.NUM_PAIRS(NP), .TIMEOUT_CYCLES(TO), .TIE_WINNER(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .finished1(f1), .finished2(f2),
    .winner(w0), .valid(v0), .tie(t0), .busy(b0), .done(d0), .timed_out(to0));

  multi_race_arbiter #(.NUM_PAIRS(NP), .TIMEOUT_CYCLES(TO), .TIE_WINNER(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .finished1(f1), .finished2(f2),
    .winner(w1), .valid(v1), .tie(t1), .busy(b1), .done(d1), .timed_out(to1));

  always #5 clk = ~clk;

  typedef struct {
    logic [NP-1:0] w0, w1, v, t;
    logic          to;
    int            dc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, failures = 0;
  int   r1[NP], r2[NP], dr1[NP], dr2[NP];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic flag(input int c, input int r, input int d);
    return (r != 0) && (c >= r) && (d == 0 || c < d);
  endfunction

  task automatic clr_sched();
    for (int p = 0; p < NP; p++) begin
      r1[p] = 0; r2[p] = 0; dr1[p] = 0; dr2[p] = 0;
    end
  endtask

  // Reference: first RACE cycle (1..TO) in which either flag is high decides the pair.
  task automatic push_model();
    exp_t e;
    int   last;
    logic a, b;
    e.w0 = '0; e.w1 = '0; e.v = '0; e.t = '0;
    last = 0;
    for (int c = 1; c <= TO; c++)
      for (int p = 0; p < NP; p++) begin
        a = flag(c, r1[p], dr1[p]);
        b = flag(c, r2[p], dr2[p]);
        if (!e.v[p] && (a || b)) begin
          e.v[p]  = 1'b1;
          e.t[p]  = a & b;
          e.w0[p] = (a & b) ? 1'b0 : a;
          e.w1[p] = (a & b) ? 1'b1 : a;
          last    = c;
        end
      end
    e.to = (e.v != '1);
    e.dc = e.to ? TO : ((last < TO) ? last + 1 : TO);
    sb.push_back(e);
  endtask

  task automatic do_start(input string tag);
    f1 = '0; f2 = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_start_busy"}, {b0, b1, d0, d1}, 4'b1100);
    chk({tag, "_start_clear"}, {v0, w0, t0, v1, w1, t1, 2'b00, to0, to1}, '0);
  endtask

  task automatic run_race(input string tag, input int sc);
    exp_t e;
    bit   got;
    push_model();
    do_start(tag);
    got = 0;
    for (int c = 1; c <= TO + 4; c++) begin
      for (int p = 0; p < NP; p++) begin
        f1[p] = flag(c, r1[p], dr1[p]);
        f2[p] = flag(c, r2[p], dr2[p]);
      end
      start = (c == sc);
      tick();
      start = 1'b0;
      if (d0 === 1'b1) begin
        e = sb.pop_front();
        chk({tag, "_done_cycle"}, c, e.dc);
        chk({tag, "_done1_busy"}, {d1, b0, b1}, 3'b100);
        chk({tag, "_winner0"}, w0, e.w0);
        chk({tag, "_winner1"}, w1, e.w1);
        chk({tag, "_valid"}, {v0, v1}, {e.v, e.v});
        chk({tag, "_tie"}, {t0, t1}, {e.t, e.t});
        chk({tag, "_timed_out"}, {to0, to1}, {e.to, e.to});
        got = 1;
        break;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $error("FAIL %s_done_bound observed=no_done expected=done_by_%0d", tag, TO);
      void'(sb.pop_front());
      return;
    end
    // Results must hold while done is high regardless of flag activity.
    for (int k = 0; k < 3; k++) begin
      f1 = NP'($urandom);
      f2 = NP'($urandom);
      tick();
      chk({tag, "_hold"}, {d0, w0, v0, t0, to0}, {1'b1, e.w0, e.v, e.t, e.to});
    end
    f1 = '0; f2 = '0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("reset_outs", {w0, v0, t0, b0, d0, to0}, '0);
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", {b0, d0, b1, d1}, '0);

    clr_sched();
    r1[0] = 3; r1[1] = 5; r1[2] = 7; r2[3] = 4;
    run_race("basic", 0);

    clr_sched();
    r1[0] = 1; r1[1] = 2; r2[1] = 2; r2[2] = 3; r1[3] = 4;
    run_race("tie", 0);

    clr_sched();
    r2[0] = 2; r1[0] = 6; dr1[0] = 9; dr2[0] = 9;
    r1[1] = 10; r2[2] = 10; r1[3] = 11;
    run_race("late_loser", 0);

    clr_sched();
    r1[0] = 1;
    run_race("timeout", 0);

    clr_sched();
    r1[0] = 1; r2[1] = 2; r1[2] = 3; r2[3] = TO;
    run_race("coincide", 0);

    clr_sched();
    r1[0] = 1; r2[1] = 2; r1[2] = 5; r1[3] = 6;
    run_race("start_in_race", 3);

    // Reset mid-race after two decisions; start held alongside reset must be ignored.
    clr_sched();
    do_start("rst_mid");
    f1 = 4'b0001; tick();
    f2 = 4'b0010; tick();
    chk("rst_mid_two", {v0, w0}, {4'b0011, 4'b0001});
    rst_n = 1'b0; start = 1'b1;
    tick();
    chk("rst_mid_outs", {w0, v0, t0, b0, d0, to0, w1, v1, t1, b1, d1, to1}, '0);
    rst_n = 1'b1; start = 1'b0; f1 = '0; f2 = '0;
    tick();
    chk("rst_mid_idle", {b0, d0}, 2'b00);

    clr_sched();
    r2[0] = 1; r1[1] = 1; r2[1] = 1; r1[2] = 2; r2[3] = 8;
    run_race("restart", 0);

    for (int n = 0; n < 3; n++) begin
      clr_sched();
      for (int p = 0; p < NP; p++) begin
        r1[p] = $urandom_range(0, TO + 2);
        r2[p] = $urandom_range(0, TO + 2);
      end
      run_race($sformatf("rand%0d", n), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
